// File: rtl/sc_matrix_pkg.sv
// rtl/sc_matrix_pkg.sv - shared scan state encoding, size defaults and off-level constants
package sc_matrix_pkg;

  localparam int ROWS_DEFAULT      = 8;
  localparam int DATAWIDTH_DEFAULT = 8;

  // Wide fill patterns; each user slices them to its own bus width.
  localparam int              OFF_W    = 64;
  localparam logic [OFF_W-1:0] ROWS_OFF = '1;
  localparam logic [OFF_W-1:0] COLS_OFF = '0;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    DISPLAY,
    BLANK
  } scan_state_t;

  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/sc_matrix_tickcnt.sv
// rtl/sc_matrix_tickcnt.sv - loadable down-counter with terminal-count flag for row and blank durations
module sc_matrix_tickcnt #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_resetn,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic [WIDTH-1:0] o_count,
  output logic             o_tc
);

  logic [WIDTH-1:0] r_count;

  // Parks at zero so the count never runs past its terminal value.
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == '0);

endmodule

// File: rtl/sc_matrix_scan.sv
// rtl/sc_matrix_scan.sv - LED matrix row scanner with blanking gap and frame tick; SC_MATRIXSCAN_BLANK_EN enables the BLANK state
module sc_matrix_scan
  import sc_matrix_pkg::*;
#(
  parameter int DATAWIDTH   = DATAWIDTH_DEFAULT,
  parameter int ROWS        = ROWS_DEFAULT,
  parameter int ROW_TICKS   = 50000,
  parameter int BLANK_TICKS = 500,
  localparam int ROWIDX_W   = clog2_min1(ROWS)
) (
  input  logic                 SC_MATRIXSCAN_CLOCK_50,
  input  logic                 SC_MATRIXSCAN_RESET_InLow,
  input  logic                 SC_MATRIXSCAN_enable_InHigh,
  input  logic [DATAWIDTH-1:0] SC_MATRIXSCAN_rowdata_InBUS,
  output logic [ROWIDX_W-1:0]  SC_MATRIXSCAN_rowindex_OutBUS,
  output logic [ROWS-1:0]      SC_MATRIXSCAN_row_OutLow,
  output logic [DATAWIDTH-1:0] SC_MATRIXSCAN_col_OutBUS,
  output logic                 SC_MATRIXSCAN_framedone_OutHigh
);

  localparam int TICK_MAX = (ROW_TICKS > BLANK_TICKS) ? ROW_TICKS : BLANK_TICKS;
  localparam int TICK_W   = clog2_min1(TICK_MAX);

  localparam logic [ROWIDX_W-1:0]  LAST_ROW   = ROWIDX_W'(ROWS - 1);
  localparam logic [TICK_W-1:0]    ROW_LOAD   = TICK_W'(ROW_TICKS - 1);
  localparam logic [TICK_W-1:0]    TICK_ONE   = TICK_W'(1);
  localparam logic [ROWS-1:0]      STROBE_OFF = ROWS_OFF[ROWS-1:0];
  localparam logic [DATAWIDTH-1:0] DRIVE_OFF  = COLS_OFF[DATAWIDTH-1:0];
  localparam logic [ROWS-1:0]      ROW_ONE    = ROWS'(1);
`ifdef SC_MATRIXSCAN_BLANK_EN
  localparam logic [TICK_W-1:0]    BLANK_LOAD = TICK_W'(BLANK_TICKS - 1);
`endif

  scan_state_t r_state;
  scan_state_t w_state_nxt;

  logic [ROWIDX_W-1:0]  r_row;
  logic [ROWIDX_W-1:0]  r_rowindex;
  logic [DATAWIDTH-1:0] r_data;
  logic [ROWS-1:0]      r_rows_n;
  logic [DATAWIDTH-1:0] r_cols;
  logic                 r_framedone;

  logic [ROWIDX_W-1:0]  w_row_nxt;
  logic [ROWIDX_W-1:0]  w_rowindex_nxt;
  logic [DATAWIDTH-1:0] w_data_nxt;
  logic [ROWS-1:0]      w_rows_n_nxt;
  logic [DATAWIDTH-1:0] w_cols_nxt;
  logic                 w_framedone_nxt;

  logic                 w_load;
  logic [TICK_W-1:0]    w_load_val;
  logic [TICK_W-1:0]    w_count;
  logic                 w_tc;
  logic                 w_last_row;
  logic [ROWIDX_W-1:0]  w_row_inc;
  logic [ROWS-1:0]      w_strobe;

  sc_matrix_tickcnt #(
    .WIDTH(TICK_W)
  ) u_tickcnt (
    .i_clk     (SC_MATRIXSCAN_CLOCK_50),
    .i_resetn  (SC_MATRIXSCAN_RESET_InLow),
    .i_load    (w_load),
    .i_load_val(w_load_val),
    .o_count   (w_count),
    .o_tc      (w_tc)
  );

  // Explicit compare-and-clear keeps the wrap correct for non-power-of-two ROWS.
  assign w_last_row = (r_row == LAST_ROW);
  assign w_row_inc  = w_last_row ? '0 : r_row + 1'b1;
  assign w_strobe   = ~(ROW_ONE << r_row);

  always_comb begin
    w_state_nxt     = r_state;
    w_row_nxt       = r_row;
    w_rowindex_nxt  = r_rowindex;
    w_data_nxt      = r_data;
    w_rows_n_nxt    = STROBE_OFF;
    w_cols_nxt      = DRIVE_OFF;
    w_framedone_nxt = 1'b0;
    w_load          = 1'b0;
    w_load_val      = '0;

    if (!SC_MATRIXSCAN_enable_InHigh) begin
      w_state_nxt    = IDLE;
      w_row_nxt      = '0;
      w_rowindex_nxt = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt    = FETCH;
          w_rowindex_nxt = r_row;
        end
        FETCH: begin
          w_state_nxt = LATCH;
        end
        LATCH: begin
          // The bank answers one cycle after the index, so the data is valid here.
          w_state_nxt     = DISPLAY;
          w_data_nxt      = SC_MATRIXSCAN_rowdata_InBUS;
          w_rows_n_nxt    = w_strobe;
          w_cols_nxt      = SC_MATRIXSCAN_rowdata_InBUS;
          w_framedone_nxt = w_last_row && (ROW_TICKS == 1);
          w_load          = 1'b1;
          w_load_val      = ROW_LOAD;
        end
        DISPLAY: begin
          if (w_tc) begin
`ifdef SC_MATRIXSCAN_BLANK_EN
            w_state_nxt    = BLANK;
            w_load         = 1'b1;
            w_load_val     = BLANK_LOAD;
`else
            w_state_nxt    = FETCH;
            w_row_nxt      = w_row_inc;
            w_rowindex_nxt = w_row_inc;
`endif
          end else begin
            w_rows_n_nxt    = w_strobe;
            w_cols_nxt      = r_data;
            w_framedone_nxt = w_last_row && (w_count == TICK_ONE);
          end
        end
`ifdef SC_MATRIXSCAN_BLANK_EN
        BLANK: begin
          if (w_tc) begin
            w_state_nxt    = FETCH;
            w_row_nxt      = w_row_inc;
            w_rowindex_nxt = w_row_inc;
          end
        end
`endif
        default: begin
          w_state_nxt    = IDLE;
          w_row_nxt      = '0;
          w_rowindex_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge SC_MATRIXSCAN_CLOCK_50) begin
    if (!SC_MATRIXSCAN_RESET_InLow) begin
      r_state     <= IDLE;
      r_row       <= '0;
      r_rowindex  <= '0;
      r_data      <= '0;
      r_rows_n    <= STROBE_OFF;
      r_cols      <= DRIVE_OFF;
      r_framedone <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_row       <= w_row_nxt;
      r_rowindex  <= w_rowindex_nxt;
      r_data      <= w_data_nxt;
      r_rows_n    <= w_rows_n_nxt;
      r_cols      <= w_cols_nxt;
      r_framedone <= w_framedone_nxt;
    end
  end

  assign SC_MATRIXSCAN_rowindex_OutBUS   = r_rowindex;
  assign SC_MATRIXSCAN_row_OutLow        = r_rows_n;
  assign SC_MATRIXSCAN_col_OutBUS        = r_cols;
  assign SC_MATRIXSCAN_framedone_OutHigh = r_framedone;

endmodule
